// File: rtl/window_fetch_pkg.sv
// window_fetch_pkg: shared window geometry, memory command codes and FSM states for window_fetch.
package window_fetch_pkg;
  localparam int WIN_SIZE = 3;
  localparam int WIN_PIX = WIN_SIZE * WIN_SIZE;
  localparam logic [1:0] MEM_RD = 2'b10;
  localparam logic [1:0] MEM_IDLE = 2'b00;
  typedef enum logic [2:0] {S_IDLE, S_ROW_RD, S_ROW_CAP, S_COL_RD, S_COL_CAP, S_OUT, S_FIN} state_t;
  // Row loads walk the window column by column, top to bottom.
  function automatic logic [1:0] slot_r(input logic [3:0] k);
    return 2'(k % 4'd3);
  endfunction
  function automatic logic [1:0] slot_c(input logic [3:0] k);
    return 2'(k / 4'd3);
  endfunction
endpackage

// File: rtl/window_fetch_addr_gen.sv
// window_fetch_addr_gen: clamps a neighbour coordinate to the image and forms its linear address.
module window_fetch_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CNT_W = 10
) (
  input  logic [CNT_W-1:0]      x,
  input  logic [CNT_W-1:0]      y,
  input  logic [1:0]            dx,
  input  logic [1:0]            dy,
  output logic [ADDR_WIDTH-1:0] addr
);
  localparam logic [CNT_W:0] X_OVR = (CNT_W+1)'(IMG_W + 1);
  localparam logic [CNT_W:0] Y_OVR = (CNT_W+1)'(IMG_H + 1);
  localparam logic [CNT_W:0] X_MAX = (CNT_W+1)'(IMG_W - 1);
  localparam logic [CNT_W:0] Y_MAX = (CNT_W+1)'(IMG_H - 1);
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
  logic [CNT_W:0] xs, ys, cx, cy;
  // Offsets are biased by one (0,1,2 -> -1,0,+1) so the sum never goes negative.
  always_comb begin
    xs = {1'b0, x} + (CNT_W+1)'(dx);
    ys = {1'b0, y} + (CNT_W+1)'(dy);
    cx = xs == '0 ? '0 : xs == X_OVR ? X_MAX : xs - ONE;
    cy = ys == '0 ? '0 : ys == Y_OVR ? Y_MAX : ys - ONE;
    addr = ADDR_WIDTH'(cy) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(cx);
  end
endmodule

// File: rtl/window_fetch.sv
// window_fetch: streams every edge-replicated 3x3 neighbourhood of a stored image in raster order.
module window_fetch
  import window_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 32,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CNT_W = 10
) (
  input  logic                          Win_CLK,
  input  logic                          Win_RST,
  input  logic                          Win_START,
  output logic                          Win_BUSY,
  output logic                          Win_DONE,
  output logic [1:0]                    Win_MRW,
  output logic [ADDR_WIDTH-1:0]         Win_MADDR,
  input  logic [DATA_WIDTH-1:0]         Win_MDATA,
  output logic                          Win_WVALID,
  input  logic                          Win_WREADY,
  output logic [WIN_PIX*DATA_WIDTH-1:0] Win_WDATA,
  output logic [CNT_W-1:0]              Win_WX,
  output logic [CNT_W-1:0]              Win_WY
);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] x, y, x_n, y_n;
  logic [3:0] k, k_n;
  logic [DATA_WIDTH-1:0] win [WIN_SIZE][WIN_SIZE];
  logic [1:0] dx, dy;
  logic [ADDR_WIDTH-1:0] addr;
  logic rd_n, xfer;
  assign xfer = state == S_OUT && Win_WREADY;
  assign rd_n = state_n == S_ROW_RD || state_n == S_COL_RD;
  // Address is formed from next-state counters so the read strobe and address register together.
  assign dx = state_n == S_COL_RD ? 2'd2 : slot_c(k_n);
  assign dy = state_n == S_COL_RD ? k_n[1:0] : slot_r(k_n);
  assign Win_WVALID = state == S_OUT;
  assign Win_BUSY = state != S_IDLE && state != S_FIN;
  assign Win_DONE = state == S_FIN;
  assign Win_WX = x;
  assign Win_WY = y;
  for (genvar r = 0; r < WIN_SIZE; r++) begin : g_r
    for (genvar c = 0; c < WIN_SIZE; c++) begin : g_c
      assign Win_WDATA[(WIN_SIZE*r+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
    end
  end
  window_fetch_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .CNT_W(CNT_W)
  ) u_addr (
    .x(x_n),
    .y(y_n),
    .dx(dx),
    .dy(dy),
    .addr(addr)
  );
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    k_n = k;
    case (state)
      S_IDLE: if (Win_START) begin
        state_n = S_ROW_RD;
        x_n = '0;
        y_n = '0;
        k_n = '0;
      end
      S_ROW_RD: state_n = S_ROW_CAP;
      S_ROW_CAP: begin
        state_n = k == 4'd8 ? S_OUT : S_ROW_RD;
        k_n = k + 4'd1;
      end
      S_COL_RD: state_n = S_COL_CAP;
      S_COL_CAP: begin
        state_n = k == 4'd2 ? S_OUT : S_COL_RD;
        k_n = k + 4'd1;
      end
      S_OUT: if (Win_WREADY) begin
        k_n = '0;
        if (x != X_LAST) begin
          x_n = x + CNT_W'(1);
          state_n = S_COL_RD;
        end else if (y != Y_LAST) begin
          x_n = '0;
          y_n = y + CNT_W'(1);
          state_n = S_ROW_RD;
        end else begin
          state_n = S_FIN;
        end
      end
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge Win_CLK or posedge Win_RST) begin
    if (Win_RST) begin
      state <= S_IDLE;
      x <= '0;
      y <= '0;
      k <= '0;
      Win_MRW <= MEM_IDLE;
      Win_MADDR <= '0;
      win <= '{default: '0};
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      k <= k_n;
      Win_MRW <= rd_n ? MEM_RD : MEM_IDLE;
      if (rd_n) Win_MADDR <= addr;
      if (state == S_ROW_CAP) win[slot_r(k)][slot_c(k)] <= Win_MDATA;
      if (state == S_COL_CAP) win[k[1:0]][2] <= Win_MDATA;
      // Sliding right keeps two columns; the new right column is fetched next.
      if (xfer && x != X_LAST) begin
        for (int r = 0; r < WIN_SIZE; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
      end
    end
  end
endmodule

// File: tb/tb_window_fetch.sv
// tb_window_fetch: drives window_fetch on a 3x3 image held in a behavioural memory and checks every window.
module tb_window_fetch;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int W = 3;
  localparam int H = 3;
  localparam int CW = 4;
  localparam int PW = 9 * DW;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic wready = 1'b0;
  logic [1:0] mrw;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata = '0;
  logic busy, done, wvalid;
  logic [PW-1:0] wdata;
  logic [CW-1:0] wx, wy;
  logic [DW-1:0] mem [W*H];
  logic [PW-1:0] got [9];
  logic [PW-1:0] k00, k11, k22;
  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int bad_rw = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  window_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IMG_W(W),
    .IMG_H(H),
    .CNT_W(CW)
  ) dut (
    .Win_CLK(clk),
    .Win_RST(rst),
    .Win_START(start),
    .Win_BUSY(busy),
    .Win_DONE(done),
    .Win_MRW(mrw),
    .Win_MADDR(maddr),
    .Win_MDATA(mdata),
    .Win_WVALID(wvalid),
    .Win_WREADY(wready),
    .Win_WDATA(wdata),
    .Win_WX(wx),
    .Win_WY(wy)
  );

  // Fixed-latency memory: data for a read cycle is presented during the following cycle.
  always @(posedge clk) begin
    if (mrw == 2'b10) begin
      rd_cnt++;
      mdata <= (maddr < AW'(W*H)) ? mem[maddr[3:0]] : '1;
    end
    if (mrw == 2'b01) bad_rw++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_win(input int x, input int y);
    logic [PW-1:0] w;
    int px, py;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px = x + c - 1;
        py = y + r - 1;
        px = px < 0 ? 0 : px > W - 1 ? W - 1 : px;
        py = py < 0 ? 0 : py > H - 1 ? H - 1 : py;
        w[(3*r+c)*DW +: DW] = mem[py*W+px];
      end
    end
    return w;
  endfunction

  task automatic rst_check(input string tag);
    chk({tag, "_mrw"}, mrw, 0);
    chk({tag, "_maddr"}, maddr, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wx"}, wx, 0);
    chk({tag, "_wy"}, wy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_frame(input bit rnd, input int stall_idx, input bit poke);
    int idx, stall, cyc, rd0, dn0;
    bit fin;
    idx = 0;
    stall = 0;
    cyc = 0;
    fin = 0;
    rd0 = rd_cnt;
    dn0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = poke && cyc == 30;
      if (wvalid) begin
        chk("wdata", wdata, exp_win(idx % 3, idx / 3));
        chk("wx", wx, idx % 3);
        chk("wy", wy, idx / 3);
        chk("mrw_in_out", mrw, 0);
        chk("busy_in_out", busy, 1);
        if (idx < 9) got[idx] = wdata;
        if (idx == stall_idx && stall < 5) begin
          wready = 1'b0;
          stall++;
        end else begin
          wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (wready) idx++;
      end else begin
        wready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        if (done) begin
          fin = 1;
          chk("windows_at_done", idx, 9);
          chk("busy_at_done", busy, 0);
        end
      end
    end
    chk("frame_completed", fin, 1);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("read_cycles", rd_cnt - rd0, 45);
    chk("done_pulses", done_cnt - dn0, 1);
  endtask

  initial begin
    for (int i = 0; i < W * H; i++) mem[i] = DW'(i + 1);
    k00 = {24'd5, 24'd4, 24'd4, 24'd2, 24'd1, 24'd1, 24'd2, 24'd1, 24'd1};
    k11 = {24'd9, 24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
    k22 = {24'd9, 24'd9, 24'd8, 24'd9, 24'd9, 24'd8, 24'd6, 24'd6, 24'd5};
    #1 rst = 1'b1;
    #2 rst_check("reset");
    @(negedge clk) rst = 1'b0;
    run_frame(0, 2, 1);
    chk("win00_const", got[0], k00);
    chk("win11_const", got[4], k11);
    chk("win22_const", got[8], k22);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wready = 1'b1;
    repeat (25) @(negedge clk);
    #2 rst = 1'b1;
    #1 rst_check("midframe_reset");
    @(negedge clk) rst = 1'b0;
    wready = 1'b0;
    run_frame(0, -1, 0);
    chk("restart_win00", got[0], k00);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W * H; i++) mem[i] = DW'($urandom);
      run_frame(1, int'($urandom_range(0, 8)), f == 1);
    end
    chk("mrw_never_01", bad_rw, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
